// File: rtl/minmax_update_ctrl_pkg.sv
// Shared constants, empty-entry encoding and FSM state type for the min/max
// background memory controller.
package minmax_update_ctrl_pkg;

  localparam int NUM_BLOCKS = 4800;
  localparam int AW         = 13;
  localparam int DW         = 4;

  // An entry with min > max has never been learned.
  localparam logic [DW-1:0] EMPTY_MIN = {DW{1'b1}};
  localparam logic [DW-1:0] EMPTY_MAX = {DW{1'b0}};

  typedef enum logic [1:0] {
    INIT,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/minmax_update_ctrl_classify.sv
// Combinational motion classifier and min/max widening for one block value
// (module minmax_classify).
module minmax_classify
  import minmax_update_ctrl_pkg::*;
(
  input  logic [DW-1:0] val,
  input  logic [DW-1:0] thresh,
  input  logic [DW-1:0] min,
  input  logic [DW-1:0] max,
  output logic          motion,
  output logic [DW-1:0] new_min,
  output logic [DW-1:0] new_max
);

  logic          empty;
  logic [DW:0]   low_sum;
  logic [DW:0]   high_sum;

  // One extra bit keeps the tolerance sums from wrapping into false motion.
  always_comb begin
    empty    = (min > max);
    low_sum  = {1'b0, val} + {1'b0, thresh};
    high_sum = {1'b0, max} + {1'b0, thresh};
    motion   = !empty && ((low_sum < {1'b0, min}) || ({1'b0, val} > high_sum));
    if (empty) begin
      new_min = val;
      new_max = val;
    end else begin
      new_min = (val < min) ? val : min;
      new_max = (val > max) ? val : max;
    end
  end

endmodule

// File: rtl/minmax_update_ctrl.sv
// Sweep sequencer and 3-stage read/classify/write-back pipeline for the
// per-block min/max memory. Optional motion counter under MOTION_COUNT_EN.
module minmax_update_ctrl
  import minmax_update_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_start,
  output logic          init_busy,
  input  logic          learn,
  input  logic [DW-1:0] thresh,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_val,
  output logic          m_valid,
  output logic [AW-1:0] m_addr,
  output logic          m_motion,
  output logic          mem_rea,
  output logic [AW-1:0] mem_addr_read,
  input  logic [DW-1:0] mem_dout_max,
  input  logic [DW-1:0] mem_dout_min,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addr_write,
  output logic [DW-1:0] mem_din_max,
`ifdef MOTION_COUNT_EN
  output logic [AW-1:0] motion_count,
`endif
  output logic [DW-1:0] mem_din_min
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BLOCKS - 1);
  localparam logic [AW-1:0] NUM_ADDR  = AW'(NUM_BLOCKS);

  state_t        state, state_next;
  logic [AW-1:0] cnt;
  logic          accept, in_range;

  logic          s1_valid, s1_learn, s1_in_range;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_val, s1_thresh;

  logic          prev_wea;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_max, prev_min;

  logic [DW-1:0] fwd_max, fwd_min, new_max, new_min;
  logic          motion;

  assign accept        = s_valid && s_ready;
  assign in_range      = (s_addr < NUM_ADDR);
  assign mem_rea       = accept && in_range;
  assign mem_addr_read = mem_rea ? s_addr : '0;

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    init_busy  = 1'b1;
    case (state)
      INIT:  if (!init_start && cnt == LAST_ADDR) state_next = RUN;
      RUN: begin
        s_ready   = 1'b1;
        init_busy = 1'b0;
        if (init_start) state_next = DRAIN;
      end
      DRAIN: if (!s1_valid && !m_valid) state_next = INIT;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == INIT && !init_start && cnt != LAST_ADDR) cnt <= cnt + 1'b1;
      else cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_learn    <= 1'b0;
      s1_in_range <= 1'b0;
      s1_addr     <= '0;
      s1_val      <= '0;
      s1_thresh   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_learn    <= learn;
        s1_in_range <= in_range;
        s1_addr     <= s_addr;
        s1_val      <= s_val;
        s1_thresh   <= thresh;
      end
    end
  end

  // The write issued this cycle is newer than the one issued last cycle,
  // which is newer than what the read-first memory returned.
  always_comb begin
    fwd_max = mem_dout_max;
    fwd_min = mem_dout_min;
    if (mem_wea && mem_addr_write == s1_addr) begin
      fwd_max = mem_din_max;
      fwd_min = mem_din_min;
    end else if (prev_wea && prev_addr == s1_addr) begin
      fwd_max = prev_max;
      fwd_min = prev_min;
    end
  end

  minmax_classify u_classify (
    .val     (s1_val),
    .thresh  (s1_thresh),
    .min     (fwd_min),
    .max     (fwd_max),
    .motion  (motion),
    .new_min (new_min),
    .new_max (new_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid        <= 1'b0;
      m_addr         <= '0;
      m_motion       <= 1'b0;
      mem_wea        <= 1'b0;
      mem_addr_write <= '0;
      mem_din_max    <= '0;
      mem_din_min    <= '0;
      prev_wea       <= 1'b0;
      prev_addr      <= '0;
      prev_max       <= '0;
      prev_min       <= '0;
    end else begin
      prev_wea  <= mem_wea;
      prev_addr <= mem_addr_write;
      prev_max  <= mem_din_max;
      prev_min  <= mem_din_min;
      m_valid   <= s1_valid;
      if (s1_valid) begin
        m_addr   <= s1_addr;
        m_motion <= s1_in_range && motion;
      end
      if (state == INIT) begin
        mem_wea        <= 1'b1;
        mem_addr_write <= cnt;
        mem_din_max    <= EMPTY_MAX;
        mem_din_min    <= EMPTY_MIN;
      end else if (s1_valid && s1_learn && s1_in_range) begin
        mem_wea        <= 1'b1;
        mem_addr_write <= s1_addr;
        mem_din_max    <= new_max;
        mem_din_min    <= new_min;
      end else begin
        mem_wea <= 1'b0;
      end
    end
  end

`ifdef MOTION_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      motion_count <= '0;
    end else if (state == DRAIN && state_next == INIT) begin
      motion_count <= '0;
    end else if (m_valid && m_motion && motion_count != NUM_ADDR) begin
      motion_count <= motion_count + 1'b1;
    end
  end
`endif

endmodule
